// File: rtl/collision_pkg.sv
// Shared types, constants and helpers for the collision manager.
//   obj_state_t : per-object collision state (ARMED / FIRED / COOLDOWN)
//   MAX_OBJ     : largest supported object count
//   CD_CNT_W    : width of the per-object cooldown frame counter
//   popcount()  : number of set bits in a MAX_OBJ-wide vector
package collision_pkg;

   typedef enum logic [1:0] {
      ARMED,
      FIRED,
      COOLDOWN
   } obj_state_t;

   localparam int unsigned MAX_OBJ  = 16;
   localparam int unsigned CD_CNT_W = 8;

   function automatic logic [4:0] popcount(input logic [MAX_OBJ-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < MAX_OBJ; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/collision_manager_if.sv
// Drawing-request / hit-report bundle between the object drawers, the collision
// manager and the game logic.
//   master : drives frame strobe, drawing requests and enables; observes hit reports
//   slave  : the collision manager side
interface collision_manager_if #(
   parameter int unsigned NUM_OBJ = 4,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

   logic               startOfFrame;
   logic               drawing_request_player;
   logic [NUM_OBJ-1:0] drawing_request_obj;
   logic [NUM_OBJ-1:0] obj_enable;
   logic [NUM_OBJ-1:0] hit_pulse;
   logic [NUM_OBJ-1:0] frame_hit_vec;
   logic               first_hit_valid;
   logic [IDX_W-1:0]   first_hit_idx;
   logic [CNT_W-1:0]   hit_count;

   modport master (
      output startOfFrame, drawing_request_player, drawing_request_obj, obj_enable,
      input  hit_pulse, frame_hit_vec, first_hit_valid, first_hit_idx, hit_count
   );

   modport slave (
      input  startOfFrame, drawing_request_player, drawing_request_obj, obj_enable,
      output hit_pulse, frame_hit_vec, first_hit_valid, first_hit_idx, hit_count
   );
endinterface

// File: rtl/collision_channel.sv
// One object's collision FSM: at most one registered hit pulse per frame, optionally
// followed by a multi-frame cooldown (built when COLLISION_COOLDOWN_EN is defined).
//   clk, resetN   : clock, synchronous active-high reset
//   raw_i         : player/object overlap for this object this cycle
//   enable_i      : collision enable; low forces ARMED and suppresses the pulse
//   sof_i         : start-of-frame strobe
//   pulse_o       : registered one-cycle hit pulse
//   pulse_next_o  : value pulse_o takes after the next edge
module collision_channel
   import collision_pkg::*;
#(
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic clk,
   input  logic resetN,
   input  logic raw_i,
   input  logic enable_i,
   input  logic sof_i,
   output logic pulse_o,
   output logic pulse_next_o
);

   obj_state_t state_q, state_d, state_f;
   logic       pulse_q, pulse_d;

`ifdef COLLISION_COOLDOWN_EN
   localparam logic [CD_CNT_W-1:0] CdLoad = CD_CNT_W'(COOLDOWN_FRAMES - 1);
   logic [CD_CNT_W-1:0] cnt_q, cnt_d;
`else
   logic unused_cooldown;
   assign unused_cooldown = ^COOLDOWN_FRAMES;
`endif

   always_comb begin
      state_f = state_q;
`ifdef COLLISION_COOLDOWN_EN
      cnt_d = cnt_q;
`endif
      // Frame transition first; raw is then judged against the post-frame state.
      if (sof_i) begin
         unique case (state_q)
`ifdef COLLISION_COOLDOWN_EN
            FIRED: begin
               state_f = COOLDOWN;
               cnt_d   = CdLoad;
            end
            COOLDOWN: begin
               if (cnt_q == '0) state_f = ARMED;
               else             cnt_d   = cnt_q - 1'b1;
            end
`else
            FIRED:    state_f = ARMED;
            COOLDOWN: state_f = ARMED;
`endif
            default:  state_f = state_q;
         endcase
      end

      state_d = state_f;
      pulse_d = 1'b0;
      if (state_f == ARMED && raw_i) begin
         pulse_d = 1'b1;
         state_d = FIRED;
      end

      if (!enable_i) begin
         state_d = ARMED;
         pulse_d = 1'b0;
`ifdef COLLISION_COOLDOWN_EN
         cnt_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q <= ARMED;
         pulse_q <= 1'b0;
`ifdef COLLISION_COOLDOWN_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pulse_q <= pulse_d;
`ifdef COLLISION_COOLDOWN_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign pulse_o      = pulse_q;
   assign pulse_next_o = pulse_d;

endmodule

// File: rtl/collision_manager.sv
// Per-frame collision manager: one hit pulse per object per frame (plus optional
// cooldown via COLLISION_COOLDOWN_EN), previous-frame collision map, first-hit latch
// and a saturating hit counter.
//   clk, resetN : clock, synchronous active-high reset
//   bus (slave) : startOfFrame, drawing requests and enables in; hit_pulse,
//                 frame_hit_vec, first_hit_valid/idx, hit_count out
module collision_manager
   import collision_pkg::*;
#(
   parameter int unsigned NUM_OBJ         = 4,
   parameter int unsigned COOLDOWN_FRAMES = 8,
   parameter int unsigned CNT_W           = 8
) (
   input logic                clk,
   input logic                resetN,
   collision_manager_if.slave bus
);

   localparam int unsigned IdxW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int unsigned SumW = CNT_W + 5;

   logic [NUM_OBJ-1:0] raw, pulse, pulse_next;
   logic [NUM_OBJ-1:0] acc_q, acc_d, frame_hit_q, frame_hit_d;
   logic               first_valid_q, first_valid_d;
   logic [IdxW-1:0]    first_idx_q, first_idx_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [SumW-1:0]    count_sum;

   assign raw = {NUM_OBJ{bus.drawing_request_player}} & bus.drawing_request_obj
                & bus.obj_enable;

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_ch
      collision_channel #(
         .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
      ) u_ch (
         .clk          (clk),
         .resetN       (resetN),
         .raw_i        (raw[i]),
         .enable_i     (bus.obj_enable[i]),
         .sof_i        (bus.startOfFrame),
         .pulse_o      (pulse[i]),
         .pulse_next_o (pulse_next[i])
      );
   end

   always_comb begin
      // Accumulator snapshot excludes the start-of-frame cycle's overlap.
      frame_hit_d = frame_hit_q;
      acc_d       = acc_q | raw;
      if (bus.startOfFrame) begin
         frame_hit_d = acc_q;
         acc_d       = raw;
      end

      // Latched alongside the pulse register so first_hit_* rises with hit_pulse.
      first_valid_d = first_valid_q & ~bus.startOfFrame;
      first_idx_d   = first_idx_q;
      if (!first_valid_d && (pulse_next != '0)) begin
         first_valid_d = 1'b1;
         for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (pulse_next[i]) first_idx_d = IdxW'(i);
         end
      end

      count_sum = SumW'(count_q) + SumW'(popcount(MAX_OBJ'(pulse)));
      if (count_sum > SumW'({CNT_W{1'b1}})) count_d = '1;
      else                                  count_d = count_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         acc_q         <= '0;
         frame_hit_q   <= '0;
         first_valid_q <= 1'b0;
         first_idx_q   <= '0;
         count_q       <= '0;
      end else begin
         acc_q         <= acc_d;
         frame_hit_q   <= frame_hit_d;
         first_valid_q <= first_valid_d;
         first_idx_q   <= first_idx_d;
         count_q       <= count_d;
      end
   end

   assign bus.hit_pulse       = pulse;
   assign bus.frame_hit_vec   = frame_hit_q;
   assign bus.first_hit_valid = first_valid_q;
   assign bus.first_hit_idx   = first_idx_q;
   assign bus.hit_count       = count_q;

endmodule

// File: tb/tb_collision_manager.sv
// Randomized bench for collision_manager against a frame-number based reference model:
// an object may pulse when it overlaps and either has not hit since reset/disable, or
// its last hit lies at least Gap frames back.
module tb_collision_manager;

   localparam int unsigned NumObj   = 4;
   localparam int unsigned CdFrames = 3;
   localparam int unsigned CntW     = 8;
   localparam int          CntMax   = (1 << CntW) - 1;
`ifdef COLLISION_COOLDOWN_EN
   localparam int          Gap      = CdFrames + 1;
`else
   localparam int          Gap      = 1;
`endif

   logic clk = 1'b0;
   logic resetN;

   always #5 clk = ~clk;

   collision_manager_if #(.NUM_OBJ(NumObj), .CNT_W(CntW)) bus ();

   collision_manager #(
      .NUM_OBJ         (NumObj),
      .COOLDOWN_FRAMES (CdFrames),
      .CNT_W           (CntW)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   int                frame_no;
   bit                fresh_m   [NumObj];
   int                hit_frame [NumObj];
   logic [NumObj-1:0] acc_m, fhv_m, pulse_m;
   bit                fv_m;
   int                fidx_m;
   int                count_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      frame_no = 0;
      for (int i = 0; i < NumObj; i++) begin
         fresh_m[i]   = 1'b1;
         hit_frame[i] = 0;
      end
      acc_m   = '0;
      fhv_m   = '0;
      pulse_m = '0;
      fv_m    = 1'b0;
      fidx_m  = 0;
      count_m = 0;
   endtask

   task automatic step(input bit rst, input bit sof, input bit pl,
                       input logic [NumObj-1:0] obj, input logic [NumObj-1:0] en);
      logic [NumObj-1:0] raw, p;
      resetN                     = rst;
      bus.startOfFrame           = sof;
      bus.drawing_request_player = pl;
      bus.drawing_request_obj    = obj;
      bus.obj_enable             = en;
      raw = {NumObj{pl}} & obj & en;

      if (rst) begin
         model_reset();
      end else begin
         count_m = count_m + $countones(pulse_m);
         if (count_m > CntMax) count_m = CntMax;
         if (sof) begin
            frame_no++;
            fhv_m = acc_m;
            acc_m = raw;
            fv_m  = 1'b0;
         end else begin
            acc_m = acc_m | raw;
         end
         p = '0;
         for (int i = 0; i < NumObj; i++) begin
            if (!en[i]) begin
               fresh_m[i] = 1'b1;
            end else if (raw[i] && (fresh_m[i] || frame_no >= hit_frame[i] + Gap)) begin
               p[i]         = 1'b1;
               fresh_m[i]   = 1'b0;
               hit_frame[i] = frame_no;
            end
         end
         if (!fv_m && p != '0) begin
            fv_m = 1'b1;
            for (int i = NumObj - 1; i >= 0; i--) if (p[i]) fidx_m = i;
         end
         pulse_m = p;
      end

      @(posedge clk);
      #1;
      check("hit_pulse", 32'(bus.hit_pulse), 32'(pulse_m));
      check("frame_hit_vec", 32'(bus.frame_hit_vec), 32'(fhv_m));
      check("first_hit_valid", 32'(bus.first_hit_valid), 32'(fv_m));
      if (fv_m) check("first_hit_idx", 32'(bus.first_hit_idx), 32'(fidx_m));
      check("hit_count", 32'(bus.hit_count), 32'(count_m));
   endtask

   task automatic run_frame(input int len, input int dens, input logic [NumObj-1:0] en_mask,
                            input bit toggle_en, input bit allow_rst);
      logic [NumObj-1:0] obj, en;
      bit pl, rst;
      for (int c = 0; c < len; c++) begin
         pl  = ($urandom_range(0, 99) < dens);
         for (int i = 0; i < NumObj; i++) obj[i] = ($urandom_range(0, 99) < dens);
         en  = en_mask;
         if (toggle_en && $urandom_range(0, 9) == 0) en[$urandom_range(0, NumObj - 1)] ^= 1'b1;
         rst = allow_rst && (c == len / 2);
         step(rst, (c == 0), pl, obj, en);
      end
   endtask

   initial begin
      model_reset();
      step(1'b1, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0);

      // Quiet frames: everything stays at zero
      for (int f = 0; f < 3; f++) run_frame(20, 0, '1, 1'b0, 1'b0);

      // Overlap with sparse to dense activity, all objects enabled
      for (int f = 0; f < 20; f++) run_frame($urandom_range(20, 60), 30, '1, 1'b0, 1'b0);
      for (int f = 0; f < 10; f++) run_frame($urandom_range(4, 12), 90, '1, 1'b0, 1'b0);

      // Enable masks and mid-frame enable toggles
      for (int f = 0; f < 20; f++) begin
         run_frame($urandom_range(10, 40), 60, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      end

      // Mid-frame resets
      for (int f = 0; f < 4; f++) run_frame(16, 70, '1, 1'b0, 1'b1);

      // Dense short frames to drive hit_count into saturation
      for (int f = 0; f < 300; f++) run_frame(6, 95, '1, 1'b0, 1'b0);
      check("hit_count_saturated", 32'(bus.hit_count), 32'(CntMax));

      // Reset after saturation clears everything
      step(1'b1, 1'b0, 1'b1, '1, '1);
      check("count_after_reset", 32'(bus.hit_count), 32'd0);
      for (int f = 0; f < 3; f++) run_frame(12, 50, '1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
